// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and width parameters for the multiplier/MAC datapath
package mac_pkg;
  localparam int N = 32;
  localparam int P_W = 2 * N;
  localparam int G = 8;
  localparam int ACC_W = P_W + G;
  localparam int MAX_TERMS = 256;
  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  typedef enum logic [1:0] {IDLE, ACC, DONE} mac_state_e;
endpackage

// File: rtl/sat_adder.sv
// sat_adder: unsigned a + zero-extended b, clamped to all ones on carry out
module sat_adder #(
  parameter int W = 72,
  parameter int B_W = 64
) (
  input  logic [W-1:0]   a,
  input  logic [B_W-1:0] b,
  output logic [W-1:0]   sum,
  output logic           sat
);
  logic [W:0] full;
  // one extra bit captures the carry that signals saturation
  always_comb begin
    full = {1'b0, a} + (W + 1)'(b);
    sat = full[W];
    sum = full[W] ? '1 : full[W-1:0];
  end
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: framed, saturating sum of multiplier products with a valid/ready result
module mac_accumulator #(
  parameter int N = mac_pkg::N,
  parameter int G = mac_pkg::G,
  parameter int MAX_TERMS = mac_pkg::MAX_TERMS,
  localparam int P_W = 2 * N,
  localparam int ACC_W = P_W + G,
  localparam int CNT_W = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [P_W-1:0]   in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  import mac_pkg::mac_state_e, mac_pkg::IDLE, mac_pkg::ACC, mac_pkg::DONE;
  mac_state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, sum;
  logic [CNT_W-1:0] count_q, count_n;
  logic ovf_q, sat, accept, load;
  sat_adder #(.W(ACC_W), .B_W(P_W)) u_add (
    .a(acc_q),
    .b(in_prod),
    .sum(sum),
    .sat(sat)
  );
  assign in_ready = (state_q != DONE);
  assign accept = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign out_acc = acc_q;
  assign out_count = count_q;
  assign out_ovf = ovf_q;
  // next state: a load (idle or in_first) restarts the group at count 1; the group closes on in_last or at the term limit
  always_comb begin
    load = accept & ((state_q == IDLE) | in_first);
    count_n = load ? CNT_W'(1) : count_q + CNT_W'(1);
    state_d = state_q;
    if (state_q == DONE) state_d = out_ready ? IDLE : DONE;
    else if (accept) state_d = (in_last || count_n == CNT_W'(MAX_TERMS)) ? DONE : ACC;
  end
  // state, accumulator, term counter and sticky overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q <= load ? ACC_W'(in_prod) : sum;
        count_q <= count_n;
        ovf_q <= load ? 1'b0 : (ovf_q | sat);
      end
    end
  end
endmodule
